// File: rtl/fll_cfg_initiator.sv
// fll_cfg_initiator
//
// Initiator side of the FLL/PLL configuration port. Takes single register
// accesses from the SoC control bus and runs the FLL's 4-phase
// cfg_req/cfg_ack handshake. The FLL's cfg_ack and cfg_lock are
// asynchronous and are brought into clk_i through SYNC_STAGES-deep
// synchronizers. Loss of lock is kept as a sticky flag.
//
// Optional feature: define FLL_CFG_TIMEOUT_EN to build the per-phase timeout
// counter, the DRAIN state and the rsp_err_o path. Without it REQ and REL
// wait indefinitely and rsp_err_o is tied to 0.
//
// Parameters:
//   SYNC_STAGES    - flops per input synchronizer (>= 2)
//   TIMEOUT_CYCLES - cycles allowed per handshake phase (>= 1)
//
// Ports:
//   clk_i, rst_ni          - SoC clock, asynchronous active-low reset
//   cmd_valid_i/ready_o    - command handshake (accept on valid & ready)
//   cmd_we_i               - 1 = write, 0 = read
//   cmd_addr_i/wdata_i     - FLL register address / write data
//   rsp_valid_o            - one-cycle response pulse, no backpressure
//   rsp_rdata_o            - read data (0 for writes and errors)
//   rsp_err_o              - handshake timed out
//   cfg_req_o/cfg_ack_i    - 4-phase handshake to the FLL
//   cfg_add_o/cfg_data_o   - address / write data to the FLL
//   cfg_wrn_o              - 1 = read, 0 = write
//   cfg_r_data_i           - FLL read data, stable while ack is high
//   cfg_lock_i             - FLL lock (asynchronous)
//   lock_o                 - synchronized lock
//   lock_lost_o/lock_clr_i - sticky loss-of-lock flag and its clear
module fll_cfg_initiator #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [1:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        cfg_req_o,
    input  logic        cfg_ack_i,
    output logic [1:0]  cfg_add_o,
    output logic [31:0] cfg_data_o,
    output logic        cfg_wrn_o,
    input  logic [31:0] cfg_r_data_i,
    input  logic        cfg_lock_i,
    output logic        lock_o,
    output logic        lock_lost_o,
    input  logic        lock_clr_i
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("fll_cfg_initiator: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fll_cfg_initiator: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_REL   = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic                   w_ack_s;
    logic                   w_lock_s;
    logic                   r_lock_q;
    logic                   r_lock_lost;

    logic                   r_req;
    logic                   r_rsp_valid;
    logic [1:0]             r_add;
    logic [31:0]            r_data;
    logic                   r_wrn;
    logic [31:0]            r_rdata;

    logic                   w_cmd_ready;
    logic                   w_accept;
    logic                   w_capture;
    logic                   w_err_set;
    logic                   w_timeout;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack_sync  <= '0;
            r_lock_sync <= '0;
        end else begin
            r_ack_sync  <= {r_ack_sync[SYNC_STAGES-2:0], cfg_ack_i};
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], cfg_lock_i};
        end
    end

    assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-phase timeout counter
    // ------------------------------------------------------------------
`ifdef FLL_CFG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Restarts from zero on every state change, so entry to REQ and to REL
    // both see a fresh count; it only advances while waiting in those two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if ((w_state_nxt != r_state) ||
                     ((r_state != S_REQ) && (r_state != S_REL))) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign rsp_err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshake FSM: next state and strobes
    // ------------------------------------------------------------------
    // A new request is never raised while the FLL is still acking a
    // previous one.
    assign w_cmd_ready = (r_state == S_IDLE) && !w_ack_s;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i && w_cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack_s) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_REL;
                end else if (w_timeout) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_REL: begin
                if (!w_ack_s) begin
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            // A late ack after a REQ timeout is absorbed here; its data
            // never reaches the response.
            S_DRAIN: begin
                if (!w_ack_s) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    // cfg_req_o and rsp_valid_o come straight from flops so the asynchronous
    // FLL never sees decode glitches on req.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_add       <= '0;
            r_data      <= '0;
            r_wrn       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= (w_state_nxt == S_REQ);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            if (w_accept) begin
                r_add   <= cmd_addr_i;
                r_data  <= cmd_wdata_i;
                r_wrn   <= ~cmd_we_i;
                r_rdata <= '0;
            end else if (w_err_set) begin
                r_rdata <= '0;
            end else if (w_capture) begin
                r_rdata <= r_wrn ? cfg_r_data_i : 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock_q    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_lock_q <= w_lock_s;
            // A fall in the same cycle as a clear keeps the flag set.
            if (r_lock_q && !w_lock_s) begin
                r_lock_lost <= 1'b1;
            end else if (lock_clr_i) begin
                r_lock_lost <= 1'b0;
            end
        end
    end

    assign cmd_ready_o = w_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign cfg_req_o   = r_req;
    assign cfg_add_o   = r_add;
    assign cfg_data_o  = r_data;
    assign cfg_wrn_o   = r_wrn;
    assign lock_o      = w_lock_s;
    assign lock_lost_o = r_lock_lost;

endmodule

// File: tb/tb_fll_cfg_initiator.sv
module tb_fll_cfg_initiator;

    localparam int SYNC = 2;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [1:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cfg_req;
    logic        cfg_ack;
    logic [1:0]  cfg_add;
    logic [31:0] cfg_data;
    logic        cfg_wrn;
    logic [31:0] cfg_r_data;
    logic        cfg_lock = 1'b0;
    logic        lock;
    logic        lock_lost;
    logic        lock_clr = 1'b0;

    fll_cfg_initiator #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .cfg_req_o(cfg_req), .cfg_ack_i(cfg_ack), .cfg_add_o(cfg_add),
        .cfg_data_o(cfg_data), .cfg_wrn_o(cfg_wrn), .cfg_r_data_i(cfg_r_data),
        .cfg_lock_i(cfg_lock), .lock_o(lock), .lock_lost_o(lock_lost),
        .lock_clr_i(lock_clr)
    );

    always #5 clk = ~clk;

`ifdef FLL_CFG_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- FLL responder model ----------------
    logic [31:0] fll_regs [4];
    logic [31:0] ref_regs [4];
    logic [31:0] garbage = 32'h0;
    logic        fll_ack_r = 1'b0;
    bit          instant_mode = 1'b0;
    bit          force_ack = 1'b0;
    bit          noack_mode = 1'b0;
    int          ack_dly = 0;
    int          rel_dly = 0;
    bit          committed = 1'b0;

    assign cfg_ack    = force_ack | (instant_mode ? cfg_req : fll_ack_r);
    assign cfg_r_data = cfg_ack ? fll_regs[cfg_add] : garbage;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            garbage = $urandom;
            if (cfg_req && cfg_ack && !committed) begin
                if (!cfg_wrn) fll_regs[cfg_add] = cfg_data;
                committed = 1'b1;
            end
            if (!cfg_req) committed = 1'b0;
            if (!instant_mode) begin
                if (cfg_req && !fll_ack_r) begin
                    if (!noack_mode) begin
                        if (cnt >= ack_dly) begin fll_ack_r = 1'b1; cnt = 0; end
                        else cnt++;
                    end
                end else if (!cfg_req && fll_ack_r) begin
                    if (cnt >= rel_dly) begin fll_ack_r = 1'b0; cnt = 0; end
                    else cnt++;
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;
    rsp_t exp_q[$];

    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    int last_lat;
    int last_req_cycles;

    task automatic do_cmd(input bit we, input logic [1:0] a, input logic [31:0] d,
                          input bit noack, input bit stuck);
        rsp_t e;
        int   n;
        noack_mode = noack;
        @(negedge clk);
        if (stuck) begin
            force_ack = 1'b1;
            repeat (4) @(negedge clk);
        end
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        if (stuck) begin
            for (int i = 0; i < 6; i++) begin
                chk("stuck_ready", {31'd0, cmd_ready}, 32'd0);
                chk("stuck_req", {31'd0, cfg_req}, 32'd0);
                @(negedge clk);
            end
            force_ack = 1'b0;
        end
        n = 0;
        while (!cmd_ready && n < 50) begin
            if (stuck) chk("stuck_req_wait", {31'd0, cfg_req}, 32'd0);
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        if (noack && TO_EN) begin
            e.err = 1'b1; e.rdata = 32'd0;
        end else if (we) begin
            ref_regs[a] = d;
            e.err = 1'b0; e.rdata = 32'd0;
        end else begin
            e.err = 1'b0; e.rdata = ref_regs[a];
        end
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("req_rise", {31'd0, cfg_req}, 32'd1);
        chk("cfg_wrn", {31'd0, cfg_wrn}, {31'd0, ~we});
        chk("cfg_add", {30'd0, cfg_add}, {30'd0, a});
        chk("cfg_data", cfg_data, d);
        n = 1;
        last_req_cycles = 0;
        while (!rsp_valid && n < 300) begin
            if (cfg_req) last_req_cycles++;
            @(negedge clk);
            n++;
        end
        last_lat = n;
        chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_req"}, {31'd0, cfg_req}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_wrn"}, {31'd0, cfg_wrn}, 32'd0);
        chk({tag, "_add"}, {30'd0, cfg_add}, 32'd0);
        chk({tag, "_data"}, cfg_data, 32'd0);
        chk({tag, "_lock"}, {31'd0, lock}, 32'd0);
        chk({tag, "_lock_lost"}, {31'd0, lock_lost}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            fll_regs[i] = v;
            ref_regs[i] = v;
        end
        #1;
        chk_reset_vals("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write with an ack three cycles after req, then read it back
        instant_mode = 1'b0; ack_dly = 3; rel_dly = 1;
        do_cmd(1'b1, 2'd2, 32'hA5A5_0001, 1'b0, 1'b0);
        do_cmd(1'b0, 2'd2, 32'h0, 1'b0, 1'b0);

        // Read with an instantly-responding ack: latency check
        do_cmd(1'b1, 2'd1, 32'h0000_1234, 1'b0, 1'b0);
        instant_mode = 1'b1;
        do_cmd(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
        chk("latency", last_lat, 32'd7);
        instant_mode = 1'b0;

        if (TO_EN) begin
            do_cmd(1'b1, 2'd3, 32'hCAFE_F00D, 1'b1, 1'b0);
            chk("timeout_req_cycles", last_req_cycles, TO);
            do_cmd(1'b0, 2'd3, 32'h0, 1'b0, 1'b0);
        end

        // Ack stuck high while idle
        ack_dly = 0; rel_dly = 0;
        do_cmd(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);

        // Lock tracking
        @(negedge clk);
        cfg_lock = 1'b1;
        repeat (4) @(negedge clk);
        chk("lock_high", {31'd0, lock}, 32'd1);
        chk("lock_lost_idle", {31'd0, lock_lost}, 32'd0);
        cfg_lock = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lock_lost && n < 10);
        chk("lock_lost_delay", n, SYNC + 1);
        chk("lock_low", {31'd0, lock}, 32'd0);
        lock_clr = 1'b1;
        @(negedge clk);
        lock_clr = 1'b0;
        chk("lock_lost_clr", {31'd0, lock_lost}, 32'd0);
        cfg_lock = 1'b1;
        repeat (4) @(negedge clk);
        cfg_lock = 1'b0;
        repeat (SYNC) @(negedge clk);
        lock_clr = 1'b1;
        @(negedge clk);
        lock_clr = 1'b0;
        chk("lock_set_wins", {31'd0, lock_lost}, 32'd1);
        @(negedge clk);
        chk("lock_still_set", {31'd0, lock_lost}, 32'd1);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            instant_mode = ($urandom_range(0, 3) == 0);
            ack_dly = $urandom_range(0, 6);
            rel_dly = $urandom_range(0, 6);
            do_cmd($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom,
                   TO_EN && ($urandom_range(0, 7) == 0), 1'b0);
        end
        instant_mode = 1'b0;

        // Reset while REQ is active
        cfg_lock = 1'b1;
        noack_mode = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 2'd1; cmd_wdata = 32'h1111_2222;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_req", {31'd0, cfg_req}, 32'd1);
        chk("pre_reset_lock", {31'd0, lock}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        noack_mode = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("no_rsp_after_reset", n, 32'd0);
        ack_dly = 2; rel_dly = 2;
        do_cmd(1'b0, 2'd2, 32'h0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fll_cfg_initiator.md
# fll_cfg_initiator

Initiator side of the FLL/PLL configuration port: accepts single register accesses from the SoC control bus and drives the FLL's 4-phase `cfg_req`/`cfg_ack` handshake. It sits in the SoC clock domain next to the clock generator. It synchronizes the FLL's asynchronous `cfg_ack` and `cfg_lock` signals and returns read data or an error to the requester. It also tracks loss of lock as a sticky flag.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in each input synchronizer on `cfg_ack_i` and `cfg_lock_i`; minimum 2.
- `TIMEOUT_CYCLES`, 1024: cycles allowed per handshake phase before abort; must be at least 1. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- `clk_i`  in  1: SoC clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `cmd_valid_i`  in  1: command request.
- `cmd_ready_o`  out  1: command accepted on `cmd_valid_i & cmd_ready_o`.
- `cmd_we_i`  in  1: 1 = write, 0 = read.
- `cmd_addr_i`  in  2: FLL register address.
- `cmd_wdata_i`  in  32: write data.
- `rsp_valid_o`  out  1: one-cycle response pulse; no backpressure.
- `rsp_rdata_o`  out  32: read data; 0 for writes and errors.
- `rsp_err_o`  out  1: handshake timed out; valid with `rsp_valid_o`.
- `cfg_req_o`  out  1: request to the FLL.
- `cfg_ack_i`  in  1: FLL acknowledge; asynchronous.
- `cfg_add_o`  out  2: address to the FLL.
- `cfg_data_o`  out  32: write data to the FLL.
- `cfg_wrn_o`  out  1: 1 = read, 0 = write (FLL convention).
- `cfg_r_data_i`  in  32: FLL read data; stable while ack is high.
- `cfg_lock_i`  in  1: FLL lock; asynchronous.
- `lock_o`  out  1: synchronized lock.
- `lock_lost_o`  out  1: sticky, set on a 1->0 transition of the synchronized lock.
- `lock_clr_i`  in  1: clears `lock_lost_o`.

## Operation
- The FSM has five states: IDLE, REQ, REL, DRAIN, RESP.
- **IDLE**
  - `cmd_ready_o = 1` only when `ack_s == 0`, where `ack_s` is the synchronized ack.
  - On accept: register `cfg_add_o`, `cfg_data_o` and `cfg_wrn_o = ~cmd_we_i`; go to REQ.
- **REQ**
  - `cfg_req_o = 1`.
  - When `ack_s == 1`: capture `cfg_r_data_i` if reading (0 if writing), drop req, go to REL.
  - On timeout: drop req, set err, go to DRAIN.
- **REL**
  - `cfg_req_o = 0`.
  - When `ack_s == 0`: go to RESP.
  - On timeout: set err, go to RESP.
- **DRAIN**
  - Wait until `ack_s == 0`, with no timeout; then go to RESP.
  - A late ack that arrives here is absorbed. Its data is discarded.
- **RESP**
  - `rsp_valid_o = 1` for exactly one cycle; go to IDLE.
- **Timeout counter**
  - Clears on entry to REQ and to REL, then increments each cycle in that state.
  - Timeout fires when count == `TIMEOUT_CYCLES - 1`.
- **Address/data outputs**
  - `cfg_add_o`, `cfg_data_o` and `cfg_wrn_o` hold their values from accept until the next accept.
- **Error response**
  - On error, `rsp_rdata_o = 0` and `rsp_err_o = 1`.
- **Lock tracking**
  - `lock_o` is the synchronized `cfg_lock_i`.
  - `lock_lost_o` sets on a synchronized falling edge and clears on `lock_clr_i`. If both happen in the same cycle, set wins.

## Timing
- **Reset values**
  - FSM in IDLE.
  - `cfg_req_o`, `cfg_wrn_o`, `cfg_add_o`, `cfg_data_o` = 0.
  - `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o` = 0.
  - `lock_o`, `lock_lost_o` = 0; synchronizers cleared.
  - `cmd_ready_o` = 1.
- **Latency**
  - `cfg_req_o` rises on the cycle after accept.
  - Response latency with an ack responding instantly in `clk_i` terms: 1 + `SYNC_STAGES` + 1 + `SYNC_STAGES` + 1 cycles after accept, which is 7 cycles at `SYNC_STAGES = 2`.
- **Handshake rules**
  - `cfg_req_o` never rises while `ack_s == 1`.
  - `cfg_req_o` never falls before `ack_s == 1`, except on timeout.
- **Mid-transaction reset**
  - Asserting `rst_ni` low mid-transaction drops `cfg_req_o` immediately (asynchronously).
  - No response is issued for the interrupted command.
- **Back-to-back commands**
  - `cmd_valid_i` held high is accepted at the earliest on the cycle after RESP.

## Configuration
- Macro `FLL_CFG_TIMEOUT_EN`.
- **Defined:** timeout counter, DRAIN state and `rsp_err_o` behave as described above.
- **Undefined:**
  - No counter logic is built; REQ and REL wait indefinitely.
  - DRAIN is unreachable.
  - `rsp_err_o` is tied to 0.

## Test plan
- **Write:** `cmd_we=1`, addr=2, wdata=0xA5A5_0001, FLL model acks 3 cycles after req.
  - `cfg_wrn_o=0`, `cfg_add_o=2`, `cfg_data_o=0xA5A50001` while req is high.
  - `rsp_valid` pulses once with `err=0`, `rdata=0`.
- **Read:** addr=1, model returns 0x0000_1234.
  - `cfg_wrn_o=1`; `rsp_rdata_o=0x1234`.
  - Latency is 7 cycles with an ack that responds the same cycle.
- **Timeout (macro defined):** `TIMEOUT_CYCLES=16`, model never acks.
  - req is high for 16 cycles, then drops.
  - `rsp_err_o=1`, `rsp_rdata_o=0`; the next command is accepted afterwards.
- **Stuck ack:** ack is held high entering IDLE.
  - `cmd_ready_o=0` until ack falls; `cfg_req_o` stays 0 throughout.
- **Lock loss:** `cfg_lock_i` goes 1->0.
  - `lock_lost_o` sets `SYNC_STAGES`+1 cycles later.
  - `lock_clr_i` asserted in the same cycle as a second fall leaves `lock_lost_o=1`.
- **Reset mid-REQ:** assert `rst_ni=0` while REQ is active.
  - `cfg_req_o=0` immediately; no `rsp_valid_o` pulse; all outputs at reset values.
